// File: rtl/spi_slave_burst_ctrl_if.sv
// spi_slave_burst_ctrl_if: SPI pad pins plus register-file bus seen by spi_slave_burst_ctrl
interface spi_slave_burst_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic i_sck, i_cs_n, i_mosi, o_miso, o_miso_oe, o_re, o_we, o_busy;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] i_rdata, o_wdata;
    modport slave (
        input i_sck, i_cs_n, i_mosi, i_rdata,
        output o_miso, o_miso_oe, o_addr, o_re, o_we, o_wdata, o_busy
    );
    modport master (
        output i_sck, i_cs_n, i_mosi, i_rdata,
        input o_miso, o_miso_oe, o_addr, o_re, o_we, o_wdata, o_busy
    );
endinterface

// File: rtl/spi_slave_burst_ctrl.sv
// spi_slave_burst_ctrl: SPI slave burst access to a register file; write path built only with SPI_WRITE_EN
module spi_slave_burst_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input logic i_clk,
    input logic i_rst,
    spi_slave_burst_ctrl_if.slave bus
);
    localparam int HW = ADDR_W + 1;
    localparam int CW = $clog2((HW > DATA_W ? HW : DATA_W) + 1);
    typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_LOAD, DATA, WORD_END, SKIP} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_s, cs_s, mosi_s, sck_q, cs_q, rise, fall, cs_fall;
    logic [CW-1:0] bitcnt;
    logic [ADDR_W-1:0] hdr, addr;
    logic [ADDR_W:0] hdr_nxt;
    logic [DATA_W-1:0] tx;
    logic rw, miso, miso_oe, re, busy;
    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sck_s & ~sck_q;
    assign fall    = ~sck_s & sck_q;
    assign cs_fall = cs_q & ~cs_s;
    assign hdr_nxt = {hdr, mosi_s};
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= CPOL;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.i_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
            sck_q     <= sck_s;
            cs_q      <= cs_s;
        end
`ifdef SPI_WRITE_EN
    localparam bit WR_EN = 1'b1;
    logic [DATA_W-1:0] rx, wdata;
    logic we;
    // o_we rises on entry to WORD_END so it pairs with the not-yet-incremented address
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            rx    <= '0;
            wdata <= '0;
            we    <= 1'b0;
        end else begin
            we <= 1'b0;
            if (state == DATA && rise && !cs_s) begin
                rx <= {rx[DATA_W-2:0], mosi_s};
                if (rw && bitcnt == CW'(DATA_W - 1)) begin
                    we    <= 1'b1;
                    wdata <= {rx[DATA_W-2:0], mosi_s};
                end
            end
        end
    assign bus.o_we    = we;
    assign bus.o_wdata = wdata;
`else
    localparam bit WR_EN = 1'b0;
    assign bus.o_we    = 1'b0;
    assign bus.o_wdata = '0;
`endif
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state   <= IDLE;
            bitcnt  <= '0;
            hdr     <= '0;
            tx      <= '0;
            rw      <= 1'b0;
            addr    <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            re      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            re <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    state  <= HDR;
                    bitcnt <= '0;
                    busy   <= 1'b1;
                end
                HDR: if (rise) begin
                    hdr    <= hdr_nxt[ADDR_W-1:0];
                    bitcnt <= bitcnt + CW'(1);
                    if (bitcnt == CW'(ADDR_W)) begin
                        addr   <= hdr_nxt[ADDR_W-1:0];
                        rw     <= hdr_nxt[ADDR_W];
                        bitcnt <= '0;
                        state  <= hdr_nxt[ADDR_W] ? (WR_EN ? DATA : SKIP) : RD_REQ;
                        re     <= ~hdr_nxt[ADDR_W];
                    end
                end
                RD_REQ: state <= RD_LOAD;
                RD_LOAD: begin
                    tx      <= bus.i_rdata;
                    miso    <= bus.i_rdata[DATA_W-1];
                    miso_oe <= 1'b1;
                    state   <= DATA;
                end
                DATA: begin
                    if (rise) begin
                        bitcnt <= bitcnt + CW'(1);
                        if (bitcnt == CW'(DATA_W - 1)) state <= WORD_END;
                    end
                    // the first fall of a word is the one that precedes its MSB sample in mode 3
                    if (fall && bitcnt != '0) begin
                        tx   <= tx << 1;
                        miso <= tx[DATA_W-2];
                    end
                end
                WORD_END: begin
                    addr   <= addr + ADDR_W'(1);
                    bitcnt <= '0;
                    state  <= rw ? DATA : RD_REQ;
                    re     <= ~rw;
                end
                SKIP: miso_oe <= 1'b0;
                default: state <= IDLE;
            endcase
            if (cs_s && state != IDLE) begin
                state   <= IDLE;
                busy    <= 1'b0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                re      <= 1'b0;
            end
        end
    assign bus.o_miso    = miso;
    assign bus.o_miso_oe = miso_oe;
    assign bus.o_addr    = addr;
    assign bus.o_re      = re;
    assign bus.o_busy    = busy;
endmodule

// File: tb/tb_spi_slave_burst_ctrl.sv
// tb_spi_slave_burst_ctrl: directed frames against a mode-0 and a mode-3 instance
module tb_spi_slave_burst_ctrl;
    localparam int HALF = 80;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mem [128];
    logic [6:0] re0 [$];
    logic [6:0] re1 [$];
    logic [6:0] we_a [$];
    logic [7:0] we_d [$];
    logic oe0_seen = 1'b0;
    logic [31:0] r;
    spi_slave_burst_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus0 ();
    spi_slave_burst_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus1 ();
    spi_slave_burst_ctrl #(.ADDR_W(7), .DATA_W(8), .CPOL(1'b0), .SYNC_STAGES(2)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0));
    spi_slave_burst_ctrl #(.ADDR_W(7), .DATA_W(8), .CPOL(1'b1), .SYNC_STAGES(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1));
    always #5 clk = ~clk;
    assign bus0.i_rdata = mem[bus0.o_addr];
    assign bus1.i_rdata = mem[bus1.o_addr];
    always @(negedge clk) begin
        if (bus0.o_re) re0.push_back(bus0.o_addr);
        if (bus1.o_re) re1.push_back(bus1.o_addr);
        if (bus0.o_we) begin
            we_a.push_back(bus0.o_addr);
            we_d.push_back(bus0.o_wdata);
        end
        if (bus0.o_miso_oe) oe0_seen = 1'b1;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cs_lo(input bit m);
        if (m) bus1.i_cs_n = 1'b0; else bus0.i_cs_n = 1'b0;
        #10;
    endtask
    // cs_n rises one clock after the last SCK rise, landing inside WORD_END
    task automatic cs_hi(input bit m);
        if (m) bus1.i_cs_n = 1'b1; else bus0.i_cs_n = 1'b1;
        bus0.i_sck = 1'b0;
        #(6 * HALF);
    endtask
    task automatic send_bits(input bit m, input int n, input logic [31:0] v, output logic [31:0] rd);
        rd = '0;
        for (int i = n - 1; i >= 0; i--) begin
            #(HALF - 10);
            if (m) bus1.i_sck = 1'b0; else bus0.i_sck = 1'b0;
            bus0.i_mosi = v[i];
            bus1.i_mosi = v[i];
            #HALF;
            rd = {rd[30:0], m ? bus1.o_miso : bus0.o_miso};
            if (m) bus1.i_sck = 1'b1; else bus0.i_sck = 1'b1;
            #10;
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, {31'd0, bus0.o_miso}, 32'd0);
        chk({tag, "_oe"}, {31'd0, bus0.o_miso_oe}, 32'd0);
        chk({tag, "_addr"}, {25'd0, bus0.o_addr}, 32'd0);
        chk({tag, "_re"}, {31'd0, bus0.o_re}, 32'd0);
        chk({tag, "_we"}, {31'd0, bus0.o_we}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, bus0.o_wdata}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus0.o_busy}, 32'd0);
    endtask
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h55;
        mem[5] = 8'hA5;
        mem[127] = 8'h69;
        mem[0] = 8'h96;
        mem[1] = 8'hC3;
        bus0.i_sck = 1'b0; bus0.i_cs_n = 1'b1; bus0.i_mosi = 1'b0;
        bus1.i_sck = 1'b1; bus1.i_cs_n = 1'b1; bus1.i_mosi = 1'b0;
        #12;
        chk_reset("por");
        chk("por_busy1", {31'd0, bus1.o_busy}, 32'd0);
        #8;
        rst = 1'b0;
        #40;
        // mode 0 single-word read of 0x05
        cs_lo(0);
        send_bits(0, 16, 32'h0500, r);
        cs_hi(0);
        chk("rd_m0_data", {24'd0, r[7:0]}, 32'hA5);
        chk("rd_m0_re_cnt", re0.size(), 32'd1);
        chk("rd_m0_re_addr", {25'd0, re0[0]}, 32'h05);
        // mode 3 single-word read of 0x05
        cs_lo(1);
        send_bits(1, 16, 32'h0500, r);
        cs_hi(1);
        chk("rd_m3_data", {24'd0, r[7:0]}, 32'hA5);
        chk("rd_m3_re_cnt", re1.size(), 32'd1);
        chk("rd_m3_re_addr", {25'd0, re1[0]}, 32'h05);
        // three-word burst wrapping 0x7F -> 0x00 -> 0x01
        re0.delete();
        cs_lo(0);
        send_bits(0, 32, 32'h7F000000, r);
        cs_hi(0);
        chk("wrap_data", {8'd0, r[23:0]}, 32'h6996C3);
        chk("wrap_re_cnt", re0.size(), 32'd3);
        chk("wrap_re0", {25'd0, re0[0]}, 32'h7F);
        chk("wrap_re1", {25'd0, re0[1]}, 32'h00);
        chk("wrap_re2", {25'd0, re0[2]}, 32'h01);
        oe0_seen = 1'b0;
        re0.delete();
`ifdef SPI_WRITE_EN
        cs_lo(0);
        send_bits(0, 24, 32'h833CC3, r);
        cs_hi(0);
        chk("wr_cnt", we_a.size(), 32'd2);
        chk("wr_a0", {25'd0, we_a[0]}, 32'h03);
        chk("wr_d0", {24'd0, we_d[0]}, 32'h3C);
        chk("wr_a1", {25'd0, we_a[1]}, 32'h04);
        chk("wr_d1", {24'd0, we_d[1]}, 32'hC3);
        chk("wr_oe", {31'd0, oe0_seen}, 32'd0);
        chk("wr_re_cnt", re0.size(), 32'd0);
`else
        cs_lo(0);
        send_bits(0, 16, 32'h83FF, r);
        cs_hi(0);
        chk("ro_we_cnt", we_a.size(), 32'd0);
        chk("ro_oe", {31'd0, oe0_seen}, 32'd0);
        chk("ro_re_cnt", re0.size(), 32'd0);
        cs_lo(0);
        send_bits(0, 16, 32'h0500, r);
        cs_hi(0);
        chk("ro_after_data", {24'd0, r[7:0]}, 32'hA5);
`endif
        // abort after five data bits of a write header
        we_a.delete();
        we_d.delete();
        cs_lo(0);
        send_bits(0, 13, 32'h1200, r);
        bus0.i_cs_n = 1'b1;
        bus0.i_sck = 1'b0;
        #1;
        chk("abort_busy_before", {31'd0, bus0.o_busy}, 32'd1);
        #34;
        chk("abort_busy_after", {31'd0, bus0.o_busy}, 32'd0);
        #(6 * HALF - 35);
        chk("abort_we_cnt", we_a.size(), 32'd0);
        // reset during data bit 3 of a read
        cs_lo(0);
        send_bits(0, 8, 32'h05, r);
        send_bits(0, 3, 32'h0, r);
        #1;
        chk("mid_oe", {31'd0, bus0.o_miso_oe}, 32'd1);
        chk("mid_addr", {25'd0, bus0.o_addr}, 32'h05);
        rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        bus0.i_cs_n = 1'b1;
        bus0.i_sck = 1'b0;
        #8;
        rst = 1'b0;
        #(4 * HALF);
        cs_lo(0);
        send_bits(0, 16, 32'h0500, r);
        cs_hi(0);
        chk("post_rst_data", {24'd0, r[7:0]}, 32'hA5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
